// File: rtl/rad_cdc_sync_filt.sv
// rad_cdc_sync_filt: per-channel multi-flop synchronizer with an optional
// stability filter and edge/glitch pulse outputs.
//
// Build option: define RAD_CDC_FILTER_EN to compile in the stability filter
// (per-channel saturating counters plus glitch_o). Without it, sync_o is the
// raw synchronized level, glitch_o is tied low and FILTER_CYCLES is only
// range-checked.
module rad_cdc_sync_filt #(
  parameter int   WIDTH         = 8,
  parameter int   STAGES        = 2,
  parameter logic RESET         = 1'b0,
  parameter int   FILTER_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] glitch_o
);

  // Reject configurations that cannot give a metastability-safe chain or a
  // meaningful filter depth.
  generate
    if (STAGES < 2 || WIDTH < 1 || FILTER_CYCLES < 1) begin : g_param_check
      $error("rad_cdc_sync_filt: need STAGES>=2, WIDTH>=1, FILTER_CYCLES>=1");
    end
  endgenerate

  logic [WIDTH-1:0] chain_q [STAGES];
  logic [WIDTH-1:0] s_lvl;
  logic [WIDTH-1:0] sync_lvl;
  logic [WIDTH-1:0] sync_prev_q;

  // Synchronizer chain: stage 0 captures the asynchronous inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) chain_q[k] <= {WIDTH{RESET}};
    end else begin
      chain_q[0] <= async_i;
      for (int k = 1; k < STAGES; k++) chain_q[k] <= chain_q[k-1];
    end
  end

  assign s_lvl = chain_q[STAGES-1];

`ifdef RAD_CDC_FILTER_EN
  localparam int             CW       = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]         sync_q, sync_d;
  logic [WIDTH-1:0]         glitch_q, glitch_d;

  // Filter next-state: a disagreement must persist FILTER_CYCLES edges before
  // the output follows; an aborted run is reported as a glitch.
  always_comb begin
    cnt_d    = '0;
    sync_d   = sync_q;
    glitch_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s_lvl[i] == sync_q[i]) begin
        glitch_d[i] = (cnt_q[i] != '0);
      end else if (cnt_q[i] == CNT_LAST) begin
        sync_d[i] = s_lvl[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Filter state registers; reset discards any count in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      sync_q   <= {WIDTH{RESET}};
      glitch_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      sync_q   <= sync_d;
      glitch_q <= glitch_d;
    end
  end

  assign sync_lvl = sync_q;
  assign glitch_o = glitch_q;
`else
  assign sync_lvl = s_lvl;
  assign glitch_o = '0;
`endif

  // Previous output level, used to derive single-cycle edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_prev_q <= {WIDTH{RESET}};
    else        sync_prev_q <= sync_lvl;
  end

  assign sync_o = sync_lvl;
  assign rise_o = sync_lvl & ~sync_prev_q;
  assign fall_o = ~sync_lvl & sync_prev_q;

endmodule

// File: tb/tb_rad_cdc_sync_filt.sv
// Directed bench for rad_cdc_sync_filt (WIDTH=4, STAGES=2, FILTER_CYCLES=3,
// RESET=1). Expected values follow the build: filtered when
// RAD_CDC_FILTER_EN is defined, raw synchronizer otherwise.
module tb_rad_cdc_sync_filt;

  logic       clk;
  logic       rst_n;
  logic [3:0] async_i;
  logic [3:0] sync_o, rise_o, fall_o, glitch_o;

  int n_cmp  = 0;
  int n_fail = 0;

  rad_cdc_sync_filt #(
    .WIDTH        (4),
    .STAGES       (2),
    .RESET        (1'b1),
    .FILTER_CYCLES(3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (async_i),
    .sync_o  (sync_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o),
    .glitch_o(glitch_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record covers n consecutive cycles with the same input and outputs.
  typedef struct {
    logic [3:0] a;
    int         n;
    logic [3:0] s;
    logic [3:0] r;
    logic [3:0] f;
    logic [3:0] g;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [3:0] es, input logic [3:0] er,
                     input logic [3:0] ef, input logic [3:0] eg);
    n_cmp++;
    if ({sync_o, rise_o, fall_o, glitch_o} !== {es, er, ef, eg}) begin
      n_fail++;
      $display("FAIL %s: got sync=%h rise=%h fall=%h glitch=%h, want sync=%h rise=%h fall=%h glitch=%h",
               name, sync_o, rise_o, fall_o, glitch_o, es, er, ef, eg);
    end
  endtask

  initial begin
    // Phases: A drive 1000 (bits 0..2 fall from reset level), B bit0 rises,
    // C bit1 high for two cycles only, D bit2 rises with bit3 falling,
    // E bit0 falls and is interrupted by reset after four edges.
`ifdef RAD_CDC_FILTER_EN
    tbl.push_back('{4'h8, 4, 4'hF, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'h8, 1, 4'h8, 4'h0, 4'h7, 4'h0});
    tbl.push_back('{4'h8, 3, 4'h8, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'h9, 4, 4'h8, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'h9, 1, 4'h9, 4'h1, 4'h0, 4'h0});
    tbl.push_back('{4'h9, 3, 4'h9, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'hB, 2, 4'h9, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'h9, 2, 4'h9, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'h9, 1, 4'h9, 4'h0, 4'h0, 4'h2});
    tbl.push_back('{4'h9, 3, 4'h9, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'h5, 4, 4'h9, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'h5, 1, 4'h5, 4'h4, 4'h8, 4'h0});
    tbl.push_back('{4'h5, 3, 4'h5, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'h4, 4, 4'h5, 4'h0, 4'h0, 4'h0});
`else
    tbl.push_back('{4'h8, 1, 4'hF, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'h8, 1, 4'h8, 4'h0, 4'h7, 4'h0});
    tbl.push_back('{4'h8, 6, 4'h8, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'h9, 1, 4'h8, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'h9, 1, 4'h9, 4'h1, 4'h0, 4'h0});
    tbl.push_back('{4'h9, 6, 4'h9, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'hB, 1, 4'h9, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'hB, 1, 4'hB, 4'h2, 4'h0, 4'h0});
    tbl.push_back('{4'h9, 1, 4'hB, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'h9, 1, 4'h9, 4'h0, 4'h2, 4'h0});
    tbl.push_back('{4'h9, 4, 4'h9, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'h5, 1, 4'h9, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'h5, 1, 4'h5, 4'h4, 4'h8, 4'h0});
    tbl.push_back('{4'h5, 6, 4'h5, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'h4, 1, 4'h5, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'h4, 1, 4'h4, 4'h0, 4'h1, 4'h0});
    tbl.push_back('{4'h4, 2, 4'h4, 4'h0, 4'h0, 4'h0});
`endif

    // Reset with all inputs held high: everything sits at RESET, no pulses.
    rst_n   = 1'b1;
    async_i = 4'hF;
    #2 rst_n = 1'b0;
    #1 chk("reset_async", 4'hF, 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("reset_held", 4'hF, 4'h0, 4'h0, 4'h0);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("post_release", 4'hF, 4'h0, 4'h0, 4'h0);
    end

    // Table-driven main sequence.
    for (int v = 0; v < tbl.size(); v++) begin
      for (int c = 0; c < tbl[v].n; c++) begin
        @(negedge clk) async_i = tbl[v].a;
        @(posedge clk); #1;
        chk($sformatf("vec%0d_cyc%0d", v, c), tbl[v].s, tbl[v].r, tbl[v].f, tbl[v].g);
      end
    end

    // Reset mid-filter (bit0 count at 2 in the filtered build): output
    // returns to RESET at once, and nothing pulses after release.
    #2 rst_n = 1'b0;
    #1 chk("midreset_immediate", 4'hF, 4'h0, 4'h0, 4'h0);
    async_i = 4'hF;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("midreset_held", 4'hF, 4'h0, 4'h0, 4'h0);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("midreset_after", 4'hF, 4'h0, 4'h0, 4'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
